// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, opcodes and helpers for the instruction fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam int ENTRY_W = 64;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BLT   = 6'd6;
  localparam logic [5:0] OP_BLE   = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LI    = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO; flush wins over push/pop
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk_i) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: single-outstanding imem reads into a prefetch FIFO
// Optional FETCH_PERF_EN adds fetched/flushed/stall event counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [5:0]  instr_op_o,
  output logic [31:0] pc_plus4_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_flushed_o,
  output logic [31:0] perf_stall_o
`endif
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [31:0]           r_fetch_pc;
  logic [31:0]           w_fetch_pc_nxt;
  logic [31:0]           w_redirect_pc;
  logic                  w_fire;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_pending;
  logic                  w_room;
  logic                  w_full;
  logic                  w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic [ENTRY_W-1:0]    w_head;

  assign w_redirect_pc = redirect_pc_i & ~32'h3;
  assign w_pending     = (r_state == WAIT);
  assign w_room        = (32'(w_count) + 32'(w_pending)) < 32'(DEPTH);
  assign imem_req_o    = !rst_i && (r_state == REQ) && w_room;
  assign imem_addr_o   = r_fetch_pc;
  assign w_fire        = imem_req_o && imem_gnt_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_push         = 1'b0;
    case (r_state)
      REQ: begin
        if (w_fire) begin
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          w_state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          w_push      = 1'b1;
          w_state_nxt = REQ;
        end
      end
      DROP: begin
        if (imem_rvalid_i) begin
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = REQ;
    endcase
    // A redirect squashes any response in this cycle and poisons one still in flight.
    if (redirect_i) begin
      w_fetch_pc_nxt = w_redirect_pc;
      w_push         = 1'b0;
      if ((r_state == REQ && w_fire) || (r_state == WAIT && !imem_rvalid_i)) begin
        w_state_nxt = DROP;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= REQ;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  assign w_pop = instr_valid_o && instr_ready_i && !redirect_i;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  ({imem_rdata_i, r_fetch_pc}),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign instr_valid_o = !w_empty;
  assign instr_o       = w_empty ? 32'd0 : w_head[63:32];
  assign pc_plus4_o    = w_empty ? 32'd0 : w_head[31:0];
  assign instr_op_o    = opcode_of(instr_o);

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;
  logic [31:0] r_perf_stall;
  logic        w_drop_rsp;
  logic [31:0] w_flush_cnt;

  assign w_drop_rsp  = imem_rvalid_i && (r_state == DROP || (r_state == WAIT && redirect_i));
  assign w_flush_cnt = (redirect_i ? 32'(w_count) : 32'd0) + 32'(w_drop_rsp);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
      r_perf_stall   <= '0;
    end else begin
      r_perf_fetched <= sat_add(r_perf_fetched, 32'(w_push));
      r_perf_flushed <= sat_add(r_perf_flushed, w_flush_cnt);
      r_perf_stall   <= sat_add(r_perf_stall, 32'(!instr_valid_o && !redirect_i));
    end
  end

  assign perf_fetched_o = r_perf_fetched;
  assign perf_flushed_o = r_perf_flushed;
  assign perf_stall_o   = r_perf_stall;
`endif

endmodule
